// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use hazard detection, bubble
//            insertion on hazard or EX flush, and saturating bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             valid_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [4:0]       RD_ID,
    input  logic             useRS1_ID,
    input  logic             useRS2_ID,
    input  logic             regWrite_ID,
    input  logic             memRead_ID,
    input  logic             memWrite_ID,
    input  logic [XLEN-1:0]  PC_ID,
    input  logic [XLEN-1:0]  IMM_ID,
    input  logic [XLEN-1:0]  RS1_DATA_ID,
    input  logic [XLEN-1:0]  RS2_DATA_ID,
    input  logic             flush_EX,
    output logic             valid_EX,
    output logic             regWrite_EX,
    output logic             memRead_EX,
    output logic             memWrite_EX,
    output logic [4:0]       RS1_EX,
    output logic [4:0]       RS2_EX,
    output logic [4:0]       RD_EX,
    output logic [XLEN-1:0]  PC_EX,
    output logic [XLEN-1:0]  IMM_EX,
    output logic [XLEN-1:0]  RS1_DATA_EX,
    output logic [XLEN-1:0]  RS2_DATA_EX,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_valid;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_haz;
    logic w_bubble;

    // A load in EX whose destination is read by the ID instruction cannot forward in time.
    assign w_rs1_match = useRS1_ID && (RS1_ID == r_rd);
    assign w_rs2_match = useRS2_ID && (RS2_ID == r_rd);
    assign w_haz       = r_valid && r_mem_read && (r_rd != 5'd0) && valid_ID
                         && (w_rs1_match || w_rs2_match);
    assign w_bubble    = flush_EX || w_haz;

    // Flush wins: the ID instruction is wrong-path, so holding it would be pointless.
    assign stall = RSTn && w_haz && !flush_EX;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_bubble) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_rs1       <= 5'd0;
                r_rs2       <= 5'd0;
                r_rd        <= 5'd0;
                r_pc        <= '0;
                r_imm       <= '0;
                r_rs1_data  <= '0;
                r_rs2_data  <= '0;
            end else begin
                r_valid     <= valid_ID;
                r_reg_write <= regWrite_ID;
                r_mem_read  <= memRead_ID;
                r_mem_write <= memWrite_ID;
                r_rs1       <= RS1_ID;
                r_rs2       <= RS2_ID;
                r_rd        <= RD_ID;
                r_pc        <= PC_ID;
                r_imm       <= IMM_ID;
                r_rs1_data  <= RS1_DATA_ID;
                r_rs2_data  <= RS2_DATA_ID;
            end

            if (flush_EX) begin
                if (r_flush_cnt != C_CNT_MAX) begin
                    r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
                end
            end else if (w_haz) begin
                if (r_stall_cnt != C_CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
                end
            end
        end
    end

    assign valid_EX    = r_valid;
    assign regWrite_EX = r_reg_write;
    assign memRead_EX  = r_mem_read;
    assign memWrite_EX = r_mem_write;
    assign RS1_EX      = r_rs1;
    assign RS2_EX      = r_rs2;
    assign RD_EX       = r_rd;
    assign PC_EX       = r_pc;
    assign IMM_EX      = r_imm;
    assign RS1_DATA_EX = r_rs1_data;
    assign RS2_DATA_EX = r_rs2_data;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Randomized and directed bench for id_ex_stage against a
//            behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;
    localparam int C_MAX = (1 << CNT_W) - 1;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic            valid_ID, useRS1_ID, useRS2_ID;
    logic [4:0]      RS1_ID, RS2_ID, RD_ID;
    logic            regWrite_ID, memRead_ID, memWrite_ID;
    logic [XLEN-1:0] PC_ID, IMM_ID, RS1_DATA_ID, RS2_DATA_ID;
    logic            flush_EX;
    logic            valid_EX, regWrite_EX, memRead_EX, memWrite_EX;
    logic [4:0]      RS1_EX, RS2_EX, RD_EX;
    logic [XLEN-1:0] PC_EX, IMM_EX, RS1_DATA_EX, RS2_DATA_EX;
    logic            stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model of the instruction currently sitting in EX (all-zero means bubble)
    typedef struct {
        bit         valid, rw, mr, mw;
        int         rs1, rs2, rd;
        bit [31:0]  pc, imm, d1, d2;
    } instr_t;
    instr_t m_ex;
    int     m_scnt, m_fcnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .valid_ID(valid_ID),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
        .useRS1_ID(useRS1_ID), .useRS2_ID(useRS2_ID),
        .regWrite_ID(regWrite_ID), .memRead_ID(memRead_ID), .memWrite_ID(memWrite_ID),
        .PC_ID(PC_ID), .IMM_ID(IMM_ID), .RS1_DATA_ID(RS1_DATA_ID), .RS2_DATA_ID(RS2_DATA_ID),
        .flush_EX(flush_EX),
        .valid_EX(valid_EX), .regWrite_EX(regWrite_EX), .memRead_EX(memRead_EX),
        .memWrite_EX(memWrite_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX), .RD_EX(RD_EX),
        .PC_EX(PC_EX), .IMM_EX(IMM_EX), .RS1_DATA_EX(RS1_DATA_EX), .RS2_DATA_EX(RS2_DATA_EX),
        .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic rand_id();
        valid_ID    = ($urandom_range(0, 7) != 0);
        RS1_ID      = 5'($urandom_range(0, 7));
        RS2_ID      = 5'($urandom_range(0, 7));
        RD_ID       = 5'($urandom_range(0, 7));
        useRS1_ID   = 1'($urandom);
        useRS2_ID   = 1'($urandom);
        regWrite_ID = 1'($urandom);
        memRead_ID  = ($urandom_range(0, 2) == 0);
        memWrite_ID = 1'($urandom);
        PC_ID       = $urandom;
        IMM_ID      = $urandom;
        RS1_DATA_ID = $urandom;
        RS2_DATA_ID = $urandom;
    endtask

    task automatic set_id(input bit mr, input int rd, input bit u1, input int r1,
                          input bit u2, input int r2);
        rand_id();
        valid_ID    = 1'b1;
        memRead_ID  = mr;
        regWrite_ID = 1'b1;
        memWrite_ID = 1'b0;
        RD_ID       = 5'(rd);
        useRS1_ID   = u1;
        RS1_ID      = 5'(r1);
        useRS2_ID   = u2;
        RS2_ID      = 5'(r2);
    endtask

    // Apply the current ID inputs for one cycle: check stall, clock, check EX side.
    task automatic step();
        bit     reads_dest, haz, exp_stall;
        instr_t id_now;
        #1;
        reads_dest = (useRS1_ID && int'(RS1_ID) == m_ex.rd) || (useRS2_ID && int'(RS2_ID) == m_ex.rd);
        haz        = m_ex.valid && m_ex.mr && m_ex.rd != 0 && valid_ID && reads_dest;
        exp_stall  = RSTn && haz && !flush_EX;
        check_val("stall", stall, exp_stall);

        id_now = '{valid_ID, regWrite_ID, memRead_ID, memWrite_ID,
                   int'(RS1_ID), int'(RS2_ID), int'(RD_ID), PC_ID, IMM_ID, RS1_DATA_ID, RS2_DATA_ID};
        if (!RSTn) begin
            m_ex = '{default: 0};
            m_scnt = 0;
            m_fcnt = 0;
        end else if (flush_EX) begin
            m_ex = '{default: 0};
            if (m_fcnt < C_MAX) m_fcnt++;
        end else if (haz) begin
            m_ex = '{default: 0};
            if (m_scnt < C_MAX) m_scnt++;
        end else begin
            m_ex = id_now;
        end

        @(posedge CLK);
        #1;
        check_val("valid_EX",    valid_EX,    m_ex.valid);
        check_val("regWrite_EX", regWrite_EX, m_ex.rw);
        check_val("memRead_EX",  memRead_EX,  m_ex.mr);
        check_val("memWrite_EX", memWrite_EX, m_ex.mw);
        check_val("RS1_EX",      RS1_EX,      m_ex.rs1);
        check_val("RS2_EX",      RS2_EX,      m_ex.rs2);
        check_val("RD_EX",       RD_EX,       m_ex.rd);
        check_val("PC_EX",       PC_EX,       m_ex.pc);
        check_val("IMM_EX",      IMM_EX,      m_ex.imm);
        check_val("RS1_DATA_EX", RS1_DATA_EX, m_ex.d1);
        check_val("RS2_DATA_EX", RS2_DATA_EX, m_ex.d2);
        check_val("stall_cnt",   stall_cnt,   m_scnt);
        check_val("flush_cnt",   flush_cnt,   m_fcnt);
        @(negedge CLK);
    endtask

    initial begin
        m_ex   = '{default: 0};
        m_scnt = 0;
        m_fcnt = 0;
        RSTn = 1'b0;
        flush_EX = 1'b0;
        rand_id();
        @(negedge CLK);

        // Reset held two cycles with random ID inputs, then first load after release
        for (int i = 0; i < 2; i++) begin
            rand_id();
            step();
        end
        RSTn = 1'b1;
        rand_id();
        PC_ID = 32'h100;
        step();
        check_val("reset_release_pc", PC_EX, 32'h100);

        // Load-use on rs1: lw x5 then add x6,x5,x7
        set_id(1, 5, 0, 1, 0, 0);
        step();
        set_id(0, 6, 1, 5, 1, 7);
        #1;
        check_val("loaduse_stall", stall, 1'b1);
        step();
        check_val("loaduse_bubble_valid", valid_EX, 1'b0);
        step();
        check_val("loaduse_rs1_pass", RS1_EX, 5'd5);

        // No false stalls: rd=x0 load, unused rs2 match, non-load producer
        for (int c = 0; c < 3; c++) begin
            set_id(c != 2, (c == 0) ? 0 : 5, 0, 1, 0, 0);
            step();
            set_id(0, 6, c == 0, (c == 0) ? 0 : 3, 0, 5);
            step();
            check_val("nofalse_pass", RD_EX, 5'd6);
        end

        // Flush together with a hazard
        set_id(1, 5, 0, 1, 0, 0);
        step();
        set_id(0, 6, 1, 5, 0, 0);
        flush_EX = 1'b1;
        step();
        flush_EX = 1'b0;
        step();

        // Saturation of stall_cnt
        for (int i = 0; i < 300; i++) begin
            set_id(1, 5, 0, 1, 0, 0);
            step();
            set_id(0, 6, 0, 1, 1, 5);
            step();
            step();
        end
        check_val("stall_cnt_sat", stall_cnt, 8'd255);

        // Reset asserted in the stall cycle
        set_id(1, 5, 0, 1, 0, 0);
        step();
        set_id(0, 6, 1, 5, 0, 0);
        RSTn = 1'b0;
        step();
        check_val("midstall_reset_cnt", stall_cnt, 8'd0);
        RSTn = 1'b1;

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 2000; i++) begin
            rand_id();
            flush_EX = ($urandom_range(0, 9) == 0);
            RSTn     = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
